// File: rtl/chirp_profile_sequencer_if.sv
// Bus between the pulse controller and chirp_profile_sequencer: table config, chirp handshake, status.
// With CHIRP_DWELL_EN defined the bus also carries cfg_wr_dwell.
`timescale 1ns/1ps
interface chirp_profile_sequencer_if #(
  parameter int NUM_PROFILES = 8
);
  localparam int AW = $clog2(NUM_PROFILES);

  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [95:0]   cfg_wr_data;
`ifdef CHIRP_DWELL_EN
  logic [15:0]   cfg_wr_dwell;
`endif
  logic [AW:0]   cfg_num_active;
  logic          seq_enable;
  logic          seq_restart;
  logic          chirp_req;
  logic          chirp_ready;
  logic          chirp_done;
  logic          err_clear;
  logic          chirp_init;
  logic [127:0]  chirp_parameters_out;
  logic [AW-1:0] profile_idx;
  logic          seq_busy;
  logic          timeout_err;
  logic          req_overrun;

  modport master (
`ifdef CHIRP_DWELL_EN
    output cfg_wr_dwell,
`endif
    output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_num_active,
    output seq_enable, seq_restart, chirp_req, chirp_ready, chirp_done, err_clear,
    input  chirp_init, chirp_parameters_out, profile_idx, seq_busy, timeout_err, req_overrun
  );

  modport slave (
`ifdef CHIRP_DWELL_EN
    input  cfg_wr_dwell,
`endif
    input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_num_active,
    input  seq_enable, seq_restart, chirp_req, chirp_ready, chirp_done, err_clear,
    output chirp_init, chirp_parameters_out, profile_idx, seq_busy, timeout_err, req_overrun
  );
endinterface

// File: rtl/chirp_profile_sequencer.sv
// Per-pulse chirp parameter scheduler: loads a profile, settles, fires chirp_init, waits for chirp_done.
// Optional macro CHIRP_DWELL_EN: each profile repeats dwell+1 chirps before advancing.
`timescale 1ns/1ps
module chirp_profile_sequencer #(
  parameter int NUM_PROFILES   = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk_fmc150,
  input  logic                    aresetn,
  chirp_profile_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_PROFILES);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [95:0] DEF_ENTRY = {32'h0000_0600, 32'h0000_0001, 32'h0000_0fff};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_FIRE, S_WAIT} state_t;

  logic [95:0]   r_table [NUM_PROFILES];
  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_tmo;
  logic [127:0]  r_params;
  logic          r_init;
  logic          r_tmo_err;
  logic          r_ovr;

  logic [CW-1:0] w_eff;
  logic [CW-1:0] w_inc;
  logic [AW-1:0] w_next_idx;
  logic          w_advance;

`ifdef CHIRP_DWELL_EN
  logic [15:0]   r_dwell_tab [NUM_PROFILES];
  logic [15:0]   r_dwell_cnt;
  logic          r_dwell_live;

  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_PROFILES; i++) r_dwell_tab[i] <= '0;
    end else if (bus.cfg_wr_en) begin
      r_dwell_tab[bus.cfg_wr_addr] <= bus.cfg_wr_dwell;
    end
  end

  assign w_advance = (r_dwell_cnt == 16'd0);
`else
  assign w_advance = 1'b1;
`endif

  // Entries are only sampled in LOAD, so writes never disturb a chirp already running.
  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_PROFILES; i++) r_table[i] <= DEF_ENTRY;
    end else if (bus.cfg_wr_en) begin
      r_table[bus.cfg_wr_addr] <= bus.cfg_wr_data;
    end
  end

  always_comb begin
    w_eff = bus.cfg_num_active;
    if (bus.cfg_num_active == '0)
      w_eff = CW'(1);
    else if (bus.cfg_num_active > CW'(NUM_PROFILES))
      w_eff = CW'(NUM_PROFILES);
  end

  // Wrap also covers an index left beyond a count that was lowered mid-rotation.
  assign w_inc      = {1'b0, r_idx} + CW'(1);
  assign w_next_idx = (w_inc >= w_eff) ? '0 : w_inc[AW-1:0];

  always_ff @(posedge clk_fmc150) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_settle  <= '0;
      r_tmo     <= '0;
      r_params  <= {32'b0, DEF_ENTRY};
      r_init    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef CHIRP_DWELL_EN
      r_dwell_cnt  <= '0;
      r_dwell_live <= 1'b0;
`endif
    end else begin
      r_init <= 1'b0;
      if (bus.err_clear) begin
        r_tmo_err <= 1'b0;
        r_ovr     <= 1'b0;
      end
      if (bus.chirp_req && (r_state != S_IDLE))
        r_ovr <= 1'b1;

      if (bus.seq_restart) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
`ifdef CHIRP_DWELL_EN
        r_dwell_cnt  <= '0;
        r_dwell_live <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.seq_enable && bus.chirp_req && bus.chirp_ready)
              r_state <= S_LOAD;
          end
          S_LOAD: begin
            r_params <= {32'b0, r_table[r_idx]};
            r_settle <= SW'(SETTLE_CYCLES - 1);
            r_state  <= S_SETTLE;
`ifdef CHIRP_DWELL_EN
            if (!r_dwell_live) begin
              r_dwell_cnt  <= r_dwell_tab[r_idx];
              r_dwell_live <= 1'b1;
            end
`endif
          end
          S_SETTLE: begin
            if (r_settle == '0) begin
              r_state <= S_FIRE;
              r_init  <= 1'b1;
            end else begin
              r_settle <= r_settle - SW'(1);
            end
          end
          S_FIRE: begin
            r_tmo   <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.chirp_done) begin
              r_state <= S_IDLE;
              if (w_advance) r_idx <= w_next_idx;
`ifdef CHIRP_DWELL_EN
              if (w_advance) r_dwell_live <= 1'b0;
              else           r_dwell_cnt  <= r_dwell_cnt - 16'd1;
`endif
            end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
              r_state   <= S_IDLE;
              r_tmo_err <= 1'b1;
`ifdef CHIRP_DWELL_EN
              r_dwell_cnt  <= '0;
              r_dwell_live <= 1'b0;
`endif
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.chirp_init           = r_init;
  assign bus.chirp_parameters_out = r_params;
  assign bus.profile_idx          = r_idx;
  assign bus.seq_busy             = (r_state != S_IDLE);
  assign bus.timeout_err          = r_tmo_err;
  assign bus.req_overrun          = r_ovr;
endmodule

// File: tb/tb_chirp_profile_sequencer.sv
// Self-checking bench for chirp_profile_sequencer against a table/rotation model of the profile schedule.
`timescale 1ns/1ps
module tb_chirp_profile_sequencer;
  localparam int NP = 8;
  localparam int SC = 4;
  localparam int TO = 100;
  localparam logic [95:0] DEF = {32'h0000_0600, 32'h0000_0001, 32'h0000_0fff};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #2 clk = ~clk;

  chirp_profile_sequencer_if #(.NUM_PROFILES(NP)) bus();

  chirp_profile_sequencer #(
    .NUM_PROFILES(NP), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_fmc150(clk),
    .aresetn(rstn),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: table, dwell table, rotation position, chirps done on the current profile.
  logic [95:0] tbl [NP];
  int dw [NP];
  int m_idx, m_eff, m_cnt, m_dw_entry;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin tbl[i] = DEF; dw[i] = 0; end
    m_idx = 0; m_cnt = 0; m_dw_entry = 0;
  endtask

  task automatic model_load();
    if (m_cnt == 0) m_dw_entry = dw[m_idx];
  endtask

  task automatic model_done();
    m_cnt++;
    if (m_cnt > m_dw_entry) begin
      m_idx = (m_idx + 1) % m_eff;
      m_cnt = 0;
    end
  endtask

  task automatic set_active(input int n);
    bus.cfg_num_active = 4'(n);
    m_eff = (n == 0) ? 1 : ((n > NP) ? NP : n);
  endtask

  task automatic restart();
    bus.seq_restart = 1'b1; tick(); bus.seq_restart = 1'b0;
    m_idx = 0; m_cnt = 0;
  endtask

  task automatic wr(input int a, input logic [95:0] d, input int dwell);
    bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 3'(a); bus.cfg_wr_data = d;
`ifdef CHIRP_DWELL_EN
    bus.cfg_wr_dwell = 16'(dwell);
    dw[a] = dwell;
`else
    dw[a] = 0;
`endif
    tick(); bus.cfg_wr_en = 1'b0;
    tbl[a] = d;
  endtask

  // One full chirp: request, check load/settle/fire timing, complete with chirp_done after dly cycles.
  task automatic do_chirp(input int exp_idx, input int dly, input bit drop_en, input bit wr_mid);
    logic [127:0] exp_p;
    logic [95:0]  nv;
    bus.chirp_req = 1'b1; tick(); bus.chirp_req = 1'b0;
    n_checks++;
    if (bus.profile_idx !== 3'(exp_idx)) begin
      n_fail++; $display("FAIL idx_pre: got %0d want %0d", bus.profile_idx, exp_idx);
    end
    model_load();
    exp_p = {32'b0, tbl[exp_idx]};
    tick();
    n_checks++;
    if (bus.chirp_parameters_out !== exp_p) begin
      n_fail++; $display("FAIL params_T2: got %h want %h", bus.chirp_parameters_out, exp_p);
    end
    for (int k = 3; k <= SC + 2; k++) begin
      tick();
      bus.cfg_wr_en = 1'b0;
      n_checks++;
      if (bus.chirp_init !== ((k == SC + 2) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL init_timing T+%0d: got %b want %b", k, bus.chirp_init, (k == SC + 2));
      end
      if (k == 3) begin
        if (drop_en) bus.seq_enable = 1'b0;
        if (wr_mid) begin
          nv = {$urandom(), $urandom(), $urandom()};
          bus.cfg_wr_en = 1'b1; bus.cfg_wr_addr = 3'(exp_idx); bus.cfg_wr_data = nv;
`ifdef CHIRP_DWELL_EN
          bus.cfg_wr_dwell = 16'(dw[exp_idx]);
`endif
          tbl[exp_idx] = nv;
        end
      end
    end
    n_checks++;
    if (bus.chirp_parameters_out !== exp_p) begin
      n_fail++; $display("FAIL params_hold: got %h want %h", bus.chirp_parameters_out, exp_p);
    end
    repeat (dly) tick();
    bus.chirp_done = 1'b1; tick(); bus.chirp_done = 1'b0;
    model_done();
    n_checks++;
    if (bus.profile_idx !== 3'(m_idx) || bus.seq_busy !== 1'b0) begin
      n_fail++; $display("FAIL idx_post: got idx %0d busy %b want idx %0d busy 0", bus.profile_idx, bus.seq_busy, m_idx);
    end
    bus.seq_enable = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; repeat (3) tick(); rstn = 1'b1; tick();
    model_reset();
    n_checks++;
    if (bus.chirp_init !== 1'b0 || bus.profile_idx !== 3'd0 || bus.seq_busy !== 1'b0 ||
        bus.timeout_err !== 1'b0 || bus.req_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got init %b idx %0d busy %b tmo %b ovr %b want all 0",
                         bus.chirp_init, bus.profile_idx, bus.seq_busy, bus.timeout_err, bus.req_overrun);
    end
    n_checks++;
    if (bus.chirp_parameters_out !== {32'b0, DEF}) begin
      n_fail++; $display("FAIL reset_params: got %h want %h", bus.chirp_parameters_out, {32'b0, DEF});
    end
    set_active(2);
    do_chirp(0, 5, 1'b0, 1'b0);
    do_chirp(1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 3; i++) wr(i, {$urandom(), $urandom(), 32'h100 + 32'(i)}, 0);
    set_active(3);
    restart();
    do_chirp(0, 20, 1'b0, 1'b0);
    do_chirp(1, 20, 1'b0, 1'b0);
    do_chirp(2, 20, 1'b0, 1'b0);
    do_chirp(0, 20, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int cnt;
    int i0;
    i0 = m_idx;
    model_load();
    bus.chirp_req = 1'b1; tick(); bus.chirp_req = 1'b0;
    cnt = 1;
    while (bus.timeout_err !== 1'b1 && cnt < 300) begin tick(); cnt++; end
    m_cnt = 0;
    n_checks++;
    if (cnt != SC + 3 + TO) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles want %0d", cnt, SC + 3 + TO);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.timeout_err !== 1'b1 || bus.seq_busy !== 1'b0 || bus.profile_idx !== 3'(i0)) begin
      n_fail++; $display("FAIL timeout_state: got tmo %b busy %b idx %0d want 1 0 %0d",
                         bus.timeout_err, bus.seq_busy, bus.profile_idx, i0);
    end
    bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got %b want 0", bus.timeout_err);
    end
  endtask

  task automatic test_overrun();
    int inits = 0;
    model_load();
    for (int c = 0; c < 40; c++) begin
      bus.chirp_req  = (c == 0 || c == 3 || c == 10);
      bus.err_clear  = (c == 10);
      bus.chirp_done = (c == 26);
      tick();
      if (bus.chirp_init === 1'b1) inits++;
      if (c == 3 || c == 10) begin
        n_checks++;
        if (bus.req_overrun !== 1'b1) begin
          n_fail++; $display("FAIL overrun_set c%0d: got %b want 1", c, bus.req_overrun);
        end
      end
    end
    bus.chirp_req = 1'b0; bus.err_clear = 1'b0; bus.chirp_done = 1'b0;
    model_done();
    n_checks++;
    if (inits != 1 || bus.profile_idx !== 3'(m_idx)) begin
      n_fail++; $display("FAIL overrun_single: got inits %0d idx %0d want 1 %0d", inits, bus.profile_idx, m_idx);
    end
    bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
    n_checks++;
    if (bus.req_overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got %b want 0", bus.req_overrun);
    end
  endtask

  task automatic test_restart();
    int inits = 0;
    set_active(3);
    restart();
    do_chirp(0, 4, 1'b0, 1'b0);
    do_chirp(1, 4, 1'b0, 1'b0);
    for (int c = 0; c < 22; c++) begin
      bus.chirp_req   = (c == 0);
      bus.chirp_done  = (c == 20);
      bus.seq_restart = (c == 20);
      tick();
    end
    bus.chirp_done = 1'b0; bus.seq_restart = 1'b0;
    m_idx = 0; m_cnt = 0;
    n_checks++;
    if (bus.profile_idx !== 3'd0 || bus.seq_busy !== 1'b0 || bus.chirp_parameters_out !== {32'b0, tbl[2]}) begin
      n_fail++; $display("FAIL restart_vs_done: got idx %0d busy %b params %h want 0 0 %h",
                         bus.profile_idx, bus.seq_busy, bus.chirp_parameters_out, {32'b0, tbl[2]});
    end
    for (int c = 0; c < 14; c++) begin
      bus.chirp_req   = (c == 0);
      bus.seq_restart = (c == 3);
      tick();
      if (bus.chirp_init === 1'b1) inits++;
    end
    bus.chirp_req = 1'b0; bus.seq_restart = 1'b0;
    n_checks++;
    if (inits != 0 || bus.seq_busy !== 1'b0) begin
      n_fail++; $display("FAIL restart_settle: got inits %0d busy %b want 0 0", inits, bus.seq_busy);
    end
  endtask

  task automatic test_drop();
    int inits = 0;
    int busy = 0;
    for (int pass = 0; pass < 2; pass++) begin
      bus.chirp_ready = (pass != 0);
      bus.seq_enable  = (pass == 0);
      bus.chirp_req = 1'b1; tick(); bus.chirp_req = 1'b0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.chirp_init === 1'b1) inits++;
        if (bus.seq_busy === 1'b1) busy++;
      end
    end
    bus.chirp_ready = 1'b1; bus.seq_enable = 1'b1;
    n_checks++;
    if (inits != 0 || busy != 0 || bus.req_overrun !== 1'b0) begin
      n_fail++; $display("FAIL drop: got inits %0d busy %0d ovr %b want 0 0 0", inits, busy, bus.req_overrun);
    end
    set_active(0);
    restart();
    for (int i = 0; i < 3; i++) do_chirp(0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      set_active($urandom_range(0, 15));
      for (int i = 0; i < NP; i++) wr(i, {$urandom(), $urandom(), $urandom()}, $urandom_range(0, 2));
      restart();
      for (int k = 0; k < 7; k++)
        do_chirp(m_idx, $urandom_range(1, 40), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    bus.chirp_req = 1'b1; tick();
    bus.chirp_req = 1'b0; tick(); tick();
    bus.chirp_req = 1'b1; tick(); bus.chirp_req = 1'b0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    model_reset();
    n_checks++;
    if (bus.seq_busy !== 1'b0 || bus.profile_idx !== 3'd0 || bus.req_overrun !== 1'b0 ||
        bus.chirp_parameters_out !== {32'b0, DEF}) begin
      n_fail++; $display("FAIL reset_mid: got busy %b idx %0d ovr %b params %h want 0 0 0 %h",
                         bus.seq_busy, bus.profile_idx, bus.req_overrun, bus.chirp_parameters_out, {32'b0, DEF});
    end
    set_active(2);
    do_chirp(0, 6, 1'b0, 1'b0);
    do_chirp(1, 6, 1'b0, 1'b0);
  endtask

`ifdef CHIRP_DWELL_EN
  task automatic test_dwell();
    int exp_seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    wr(0, {$urandom(), $urandom(), 32'h0a}, 2);
    wr(1, {$urandom(), $urandom(), 32'h0b}, 0);
    set_active(2);
    restart();
    for (int i = 0; i < 8; i++) do_chirp(exp_seq[i], 4, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
`ifdef CHIRP_DWELL_EN
    bus.cfg_wr_dwell = '0;
`endif
    bus.cfg_num_active = '0; bus.seq_enable = 1'b1; bus.seq_restart = 1'b0;
    bus.chirp_req = 1'b0; bus.chirp_ready = 1'b1; bus.chirp_done = 1'b0; bus.err_clear = 1'b0;
    test_reset();
    test_sequence();
    test_timeout();
    test_overrun();
    test_restart();
    test_drop();
    test_random();
`ifdef CHIRP_DWELL_EN
    test_dwell();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/chirp_profile_sequencer.md
Name: chirp_profile_sequencer

Overview:
Per-pulse chirp parameter scheduler in the clk_fmc150 domain, placed between the radar pulse state machine and the DDS chirp generator.
- Holds a table of up to NUM_PROFILES chirp parameter sets (freq_offset, tuning_coef, counter_max).
- On each chirp request it loads the current profile onto chirp_parameters_out, waits a settle interval, fires chirp_init, waits for chirp_done, then advances round-robin through the active profiles.

Parameters:
NUM_PROFILES, 8, table depth; power of two, 2..16
SETTLE_CYCLES, 4, cycles between parameter update and chirp_init; must be >=1
TIMEOUT_CYCLES, 65535, maximum WAIT_DONE cycles before abort

Ports:
clk_fmc150  in  1  245.76 MHz clock
aresetn  in  1  synchronous, active-low reset
cfg_wr_en  in  1  table write strobe
cfg_wr_addr  in  clog2(NUM_PROFILES)  table write index
cfg_wr_data  in  96  {freq_offset, tuning_coef, counter_max}
cfg_num_active  in  clog2(NUM_PROFILES)+1  number of profiles in rotation
seq_enable  in  1  permits new chirps
seq_restart  in  1  pulse: return to profile 0
chirp_req  in  1  single-cycle chirp request from pulse controller
chirp_ready  in  1  DAC/chirp generator ready
chirp_done  in  1  single-cycle end of chirp
chirp_init  out  1  single-cycle chirp start
chirp_parameters_out  out  128  {32'b0, freq_offset, tuning_coef, counter_max}
profile_idx  out  clog2(NUM_PROFILES)  profile loaded for the current or next chirp
seq_busy  out  1  state != IDLE
timeout_err  out  1  sticky error flag
req_overrun  out  1  sticky error flag
err_clear  in  1  clears both sticky flags

Behaviour:
Reset values:
- All outputs 0.
- Table contents: {32'h0600, 32'h1, 32'h0fff} in every entry.
- chirp_parameters_out = {32'b0, 32'h0600, 32'h1, 32'h0fff}; state IDLE; index 0.

Table writes:
- Accepted in any state.
- An entry is latched only in LOAD, so a write to the entry in use affects the next load of that entry only.

Effective profile count:
- cfg_num_active = 0 is treated as 1.
- Values > NUM_PROFILES are treated as NUM_PROFILES.

States:
- IDLE: if seq_enable & chirp_req & chirp_ready -> LOAD. A chirp_req with seq_enable low, or with chirp_ready low, is dropped silently.
- LOAD (1 cycle): chirp_parameters_out <= table[profile_idx]; -> SETTLE; settle counter <= SETTLE_CYCLES-1.
- SETTLE: count down; at 0 -> FIRE.
- FIRE (1 cycle): chirp_init = 1; -> WAIT_DONE; timeout counter <= 0.
- WAIT_DONE:
  - chirp_done -> advance profile_idx (wrap to 0 after effective count-1) -> IDLE.
  - Timeout counter reaching TIMEOUT_CYCLES -> timeout_err <= 1, no advance -> IDLE.
  - chirp_done arriving in any other state is ignored.

Latency:
- chirp_req sampled at cycle T -> LOAD at T+1.
- New parameters visible at T+2.
- chirp_init high at cycle T+2+SETTLE_CYCLES; parameters are stable SETTLE_CYCLES cycles before it.

Overrun:
- chirp_req while state != IDLE sets req_overrun; the request is dropped.

seq_restart:
- In any state: profile_idx <= 0, state <= IDLE next cycle, chirp_init forced 0.
- chirp_parameters_out is held.
- Takes priority over the same-cycle chirp_done advance.

seq_enable deassert mid-sequence:
- The chirp in progress completes normally; no new LOAD is started.

err_clear together with a same-cycle error event: set wins.

Reset mid-operation: returns immediately to the reset values, including table contents.

Optional Feature:
CHIRP_DWELL_EN
- Defined:
  - Adds input cfg_wr_dwell [15:0], written alongside cfg_wr_data.
  - Each profile repeats dwell+1 chirps before advancing; a dwell counter is loaded in LOAD when the profile is first entered.
  - seq_restart and timeout reset the dwell counter.
- Undefined: port absent; the profile advances after every chirp.

Test Plan:
1. Reset, write profiles 0..2 with distinct values, cfg_num_active=3, chirp_ready=1, seq_enable=1, chirp_req at T, chirp_done 20 cycles after chirp_init:
   - Profile 0 params at T+2; chirp_init only at T+6.
   - Subsequent requests yield profile order 0,1,2,0.
2. No chirp_done after FIRE, TIMEOUT_CYCLES=100 -> timeout_err=1 after 100 WAIT_DONE cycles; state IDLE; profile_idx unchanged; err_clear -> flag 0.
3. chirp_req during SETTLE -> req_overrun=1; no second chirp_init.
4. seq_restart on the same cycle as chirp_done with profile_idx=2 -> profile_idx=0 and state IDLE.
5. chirp_ready=0 or seq_enable=0 with chirp_req -> state stays IDLE, no chirp_init; cfg_num_active=0 -> every chirp uses profile 0.
6. CHIRP_DWELL_EN defined, dwell 0 = 2, dwell 1 = 0 -> profile sequence 0,0,0,1,0,0,0,1.
